// File: rtl/regbank_wb_arbiter.sv
// regbank_wb_arbiter: round-robin write-back arbiter with bounded bursts in front of register_bank's
// single write port, plus RAW hazard flags for both read ports. Optional bypass: REGBANK_WB_BYPASS_EN.
module regbank_wb_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int NUM_LANES = 16,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SRC-1:0]                  req_valid,
  input  logic [NUM_SRC-1:0]                  req_lock,
  input  logic [NUM_SRC*ADDR_W-1:0]           req_addr,
  input  logic [NUM_SRC*NUM_LANES-1:0]        req_mask,
  input  logic [NUM_SRC*NUM_LANES*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]                  req_ready,
  input  logic                                wb_hold,
  output logic [NUM_LANES-1:0]                write_en,
  output logic [ADDR_W-1:0]                   waddr,
  output logic [NUM_LANES*DATA_W-1:0]         wdata,
  input  logic [ADDR_W-1:0]                   rd_addr_0,
  input  logic [ADDR_W-1:0]                   rd_addr_1,
  output logic                                rd_hazard_0,
  output logic                                rd_hazard_1
`ifdef REGBANK_WB_BYPASS_EN
  ,
  output logic                                byp_hit_0,
  output logic                                byp_hit_1,
  output logic [NUM_LANES*DATA_W-1:0]         byp_data_0,
  output logic [NUM_LANES*DATA_W-1:0]         byp_data_1
`endif
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int ROW_W = NUM_LANES * DATA_W;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [SRC_W-1:0]     rr_ptr_r;
  logic [SRC_W-1:0]     owner_r;
  logic [CNT_W-1:0]     burst_cnt_r;
  logic [NUM_LANES-1:0] write_en_r;
  logic [ADDR_W-1:0]    waddr_r;
  logic [ROW_W-1:0]     wdata_r;

  logic                 burst_keep_s;
  logic                 rr_any_s;
  logic [SRC_W-1:0]     rr_idx_s;
  logic                 gnt_any_s;
  logic [SRC_W-1:0]     gnt_idx_s;
  int unsigned          gnt_i_s;
  logic [NUM_SRC-1:0]   gnt_onehot_s;
  logic                 pend_hit_0_s;
  logic                 pend_hit_1_s;
  logic                 stage_hit_0_s;
  logic                 stage_hit_1_s;

  function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int off);
    int sum;
    sum = int'(32'(base)) + off;
    return SRC_W'(sum % NUM_SRC);
  endfunction

  // Burst continuation: last winner keeps the port while locked and under the burst bound
  always_comb begin
    burst_keep_s = (burst_cnt_r != {CNT_W{1'b0}}) && (burst_cnt_r < BURST_MAX) &&
                   req_lock[owner_r] && req_valid[owner_r];
  end

  // Round-robin scan from rr_ptr; descending loop leaves the nearest valid source as winner
  always_comb begin
    rr_any_s = 1'b0;
    rr_idx_s = rr_ptr_r;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      rr_any_s = rr_any_s | req_valid[wrap_idx(rr_ptr_r, i)];
      rr_idx_s = req_valid[wrap_idx(rr_ptr_r, i)] ? wrap_idx(rr_ptr_r, i) : rr_idx_s;
    end
  end

  // Final grant selection; nothing is granted in reset or while held
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = rr_idx_s;
    if (!rst_n || wb_hold) begin
      gnt_any_s = 1'b0;
      gnt_idx_s = rr_idx_s;
    end else if (burst_keep_s) begin
      gnt_any_s = 1'b1;
      gnt_idx_s = owner_r;
    end else begin
      gnt_any_s = rr_any_s;
      gnt_idx_s = rr_idx_s;
    end
  end

  // One-hot ready vector from the grant index
  always_comb begin
    gnt_onehot_s = {NUM_SRC{1'b0}};
    for (int s = 0; s < NUM_SRC; s++) begin
      gnt_onehot_s[s] = gnt_any_s && (gnt_idx_s == SRC_W'(s));
    end
  end

  assign gnt_i_s   = 32'(gnt_idx_s);
  assign req_ready = gnt_onehot_s;

  // Arbitration state: pointer, last owner and burst length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r    <= {SRC_W{1'b0}};
      owner_r     <= {SRC_W{1'b0}};
      burst_cnt_r <= {CNT_W{1'b0}};
    end else if (wb_hold) begin
      rr_ptr_r    <= rr_ptr_r;
      owner_r     <= owner_r;
      burst_cnt_r <= burst_cnt_r;
    end else if (gnt_any_s) begin
      rr_ptr_r <= wrap_idx(gnt_idx_s, 1);
      owner_r  <= gnt_idx_s;
      if ((burst_cnt_r != {CNT_W{1'b0}}) && (gnt_idx_s == owner_r)) begin
        burst_cnt_r <= (burst_cnt_r < BURST_MAX) ? burst_cnt_r + CNT_ONE : BURST_MAX;
      end else begin
        burst_cnt_r <= CNT_ONE;
      end
    end else begin
      rr_ptr_r    <= rr_ptr_r;
      owner_r     <= owner_r;
      burst_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Output stage: one cycle per grant; addr/data keep their last value when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_r <= {NUM_LANES{1'b0}};
      waddr_r    <= {ADDR_W{1'b0}};
      wdata_r    <= {ROW_W{1'b0}};
    end else if (gnt_any_s) begin
      write_en_r <= req_mask[gnt_i_s*NUM_LANES +: NUM_LANES];
      waddr_r    <= req_addr[gnt_i_s*ADDR_W +: ADDR_W];
      wdata_r    <= req_data[gnt_i_s*ROW_W +: ROW_W];
    end else begin
      write_en_r <= {NUM_LANES{1'b0}};
      waddr_r    <= waddr_r;
      wdata_r    <= wdata_r;
    end
  end

  assign write_en = write_en_r;
  assign waddr    = waddr_r;
  assign wdata    = wdata_r;

  // Pending-request hazard term: any valid source with a non-empty mask aimed at the read address
  always_comb begin
    pend_hit_0_s = 1'b0;
    pend_hit_1_s = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      pend_hit_0_s = pend_hit_0_s | (req_valid[s] & (|req_mask[s*NUM_LANES +: NUM_LANES]) &
                     (req_addr[s*ADDR_W +: ADDR_W] == rd_addr_0));
      pend_hit_1_s = pend_hit_1_s | (req_valid[s] & (|req_mask[s*NUM_LANES +: NUM_LANES]) &
                     (req_addr[s*ADDR_W +: ADDR_W] == rd_addr_1));
    end
  end

  assign stage_hit_0_s = (|write_en_r) & (waddr_r == rd_addr_0);
  assign stage_hit_1_s = (|write_en_r) & (waddr_r == rd_addr_1);

`ifdef REGBANK_WB_BYPASS_EN
  // Only a full-row write can be forwarded; partial writes still stall the reader
  assign byp_hit_0   = (&write_en_r) & (waddr_r == rd_addr_0);
  assign byp_hit_1   = (&write_en_r) & (waddr_r == rd_addr_1);
  assign byp_data_0  = wdata_r;
  assign byp_data_1  = wdata_r;
  assign rd_hazard_0 = (stage_hit_0_s & ~byp_hit_0) | pend_hit_0_s;
  assign rd_hazard_1 = (stage_hit_1_s & ~byp_hit_1) | pend_hit_1_s;
`else
  assign rd_hazard_0 = stage_hit_0_s | pend_hit_0_s;
  assign rd_hazard_1 = stage_hit_1_s | pend_hit_1_s;
`endif

  // Source protocol: a waiting request keeps valid and its address until granted
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src_chk
    a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[s] && !req_ready[s]) |=> (req_valid[s] && $stable(req_addr[s*ADDR_W +: ADDR_W])));
  end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Self-checking bench for regbank_wb_arbiter: table-driven arbitration vectors with a scoreboard
// for the output stage, plus hand-written hazard, zero-mask, bypass and reset sequences.
`timescale 1ns/1ps
module tb_regbank_wb_arbiter;

  localparam int NS = 2;
  localparam int NL = 16;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = NL * DW;
`ifdef REGBANK_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     valid_v;
  logic [NS-1:0]     lock_v;
  logic              hold_v;
  logic [AW-1:0]     src_addr [NS];
  logic [NL-1:0]     src_mask [NS];
  logic [RW-1:0]     src_data [NS];
  logic [NS*AW-1:0]  req_addr;
  logic [NS*NL-1:0]  req_mask;
  logic [NS*RW-1:0]  req_data;
  logic [NS-1:0]     req_ready;
  logic [NL-1:0]     write_en;
  logic [AW-1:0]     waddr;
  logic [RW-1:0]     wdata;
  logic [AW-1:0]     rd_addr_0;
  logic [AW-1:0]     rd_addr_1;
  logic              rd_hazard_0;
  logic              rd_hazard_1;
`ifdef REGBANK_WB_BYPASS_EN
  logic              byp_hit_0;
  logic              byp_hit_1;
  logic [RW-1:0]     byp_data_0;
  logic [RW-1:0]     byp_data_1;
`endif

  int checks = 0;
  int errors = 0;

  assign req_addr = {src_addr[1], src_addr[0]};
  assign req_mask = {src_mask[1], src_mask[0]};
  assign req_data = {src_data[1], src_data[0]};

  always #5 clk = ~clk;

  regbank_wb_arbiter #(.NUM_SRC(NS), .NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid_v), .req_lock(lock_v), .req_addr(req_addr), .req_mask(req_mask),
    .req_data(req_data), .req_ready(req_ready), .wb_hold(hold_v),
    .write_en(write_en), .waddr(waddr), .wdata(wdata),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_hazard_0(rd_hazard_0), .rd_hazard_1(rd_hazard_1)
`ifdef REGBANK_WB_BYPASS_EN
    , .byp_hit_0(byp_hit_0), .byp_hit_1(byp_hit_1), .byp_data_0(byp_data_0), .byp_data_1(byp_data_1)
`endif
  );

  typedef struct {
    logic [NS-1:0] valid;
    logic [NS-1:0] lock;
    logic          hold;
    logic [NS-1:0] exp_ready;
  } vec_t;

  typedef struct {
    logic          has_gnt;
    logic [NL-1:0] en;
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } sb_t;

  vec_t tbl [22];
  sb_t  sb_q [$];

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic advance(input int s);
    src_addr[s] = AW'($urandom_range(0, 15));
    src_mask[s] = 16'hFFFF;
    for (int l = 0; l < NL; l++) src_data[s][l*DW +: DW] = $urandom;
  endtask

  // Called at posedge+1 with inputs set; checks grant at negedge and stage after the next edge
  task automatic arb_cycle(input logic [NS-1:0] exp_rdy);
    sb_t e;
    @(negedge clk);
    chk("req_ready", RW'(req_ready), RW'(exp_rdy));
    e.has_gnt = (exp_rdy != 2'b00);
    e.en = '0; e.addr = '0; e.data = '0;
    for (int s = 0; s < NS; s++) begin
      if (exp_rdy[s]) begin
        e.en = src_mask[s]; e.addr = src_addr[s]; e.data = src_data[s];
      end
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk("write_en", RW'(write_en), RW'(e.en));
    if (e.has_gnt) begin
      chk("waddr", RW'(waddr), RW'(e.addr));
      chk("wdata", wdata, e.data);
    end
    for (int s = 0; s < NS; s++) if (exp_rdy[s]) advance(s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // round robin, burst bound, solo burst, hold, resume
    tbl[0]  = '{2'b11, 2'b00, 1'b0, 2'b01};
    tbl[1]  = '{2'b11, 2'b00, 1'b0, 2'b10};
    tbl[2]  = '{2'b11, 2'b00, 1'b0, 2'b01};
    tbl[3]  = '{2'b11, 2'b00, 1'b0, 2'b10};
    tbl[4]  = '{2'b11, 2'b01, 1'b0, 2'b01};
    tbl[5]  = '{2'b11, 2'b01, 1'b0, 2'b01};
    tbl[6]  = '{2'b11, 2'b01, 1'b0, 2'b01};
    tbl[7]  = '{2'b11, 2'b01, 1'b0, 2'b01};
    tbl[8]  = '{2'b11, 2'b01, 1'b0, 2'b10};
    tbl[9]  = '{2'b01, 2'b01, 1'b0, 2'b01};
    tbl[10] = '{2'b01, 2'b01, 1'b0, 2'b01};
    tbl[11] = '{2'b01, 2'b01, 1'b0, 2'b01};
    tbl[12] = '{2'b01, 2'b01, 1'b0, 2'b01};
    tbl[13] = '{2'b01, 2'b01, 1'b0, 2'b01};
    tbl[14] = '{2'b01, 2'b01, 1'b0, 2'b01};
    tbl[15] = '{2'b11, 2'b00, 1'b1, 2'b00};
    tbl[16] = '{2'b11, 2'b00, 1'b1, 2'b00};
    tbl[17] = '{2'b11, 2'b00, 1'b1, 2'b00};
    tbl[18] = '{2'b11, 2'b00, 1'b0, 2'b10};
    tbl[19] = '{2'b11, 2'b00, 1'b0, 2'b01};
    tbl[20] = '{2'b10, 2'b00, 1'b0, 2'b10};
    tbl[21] = '{2'b00, 2'b00, 1'b0, 2'b00};

    rst_n = 1'b0; valid_v = 2'b11; lock_v = 2'b00; hold_v = 1'b0;
    rd_addr_0 = 4'd0; rd_addr_1 = 4'd0;
    advance(0); advance(1);
    #3;
    chk("reset_ready", RW'(req_ready), RW'(2'b00));
    chk("reset_write_en", RW'(write_en), RW'(16'h0000));
    chk("reset_waddr", RW'(waddr), RW'(4'h0));
    chk("reset_wdata", wdata, {RW{1'b0}});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      valid_v = tbl[i].valid; lock_v = tbl[i].lock; hold_v = tbl[i].hold;
      arb_cycle(tbl[i].exp_ready);
    end

    // hazard: stage term on port 0, then pending term on port 1
    rd_addr_0 = 4'd5; rd_addr_1 = 4'd6;
    src_addr[0] = 4'd5; src_mask[0] = 16'hFFFF; valid_v = 2'b01;
    #1; chk("haz0_pending", RW'(rd_hazard_0), RW'(1'b1)); chk("haz1_pending_other", RW'(rd_hazard_1), RW'(1'b0));
    arb_cycle(2'b01);
    valid_v = 2'b00;
    #1; chk("haz0_stage", RW'(rd_hazard_0), RW'(!BYP)); chk("haz1_stage_other", RW'(rd_hazard_1), RW'(1'b0));
    arb_cycle(2'b00);
    src_addr[1] = 4'd6; src_mask[1] = 16'h0001; valid_v = 2'b10;
    #1; chk("haz1_pending", RW'(rd_hazard_1), RW'(1'b1)); chk("haz0_clear", RW'(rd_hazard_0), RW'(1'b0));
    arb_cycle(2'b10);
    valid_v = 2'b00;
    #1; chk("haz1_partial_stage", RW'(rd_hazard_1), RW'(1'b1));
    arb_cycle(2'b00);

    // zero-mask request still consumes a grant but writes nothing
    rd_addr_0 = 4'd9;
    src_addr[0] = 4'd9; src_mask[0] = 16'hFFFF; valid_v = 2'b01;
    arb_cycle(2'b01);
    src_addr[0] = 4'd9; src_mask[0] = 16'h0000;
    #1; chk("haz0_zero_mask", RW'(rd_hazard_0), RW'(!BYP));
    arb_cycle(2'b01);
    valid_v = 2'b00;
    #1; chk("haz0_after_zero", RW'(rd_hazard_0), RW'(1'b0));
    arb_cycle(2'b00);

    // full-row write to reg 2, then partial write
    rd_addr_0 = 4'd2;
    src_addr[0] = 4'd2; src_mask[0] = 16'hFFFF; src_data[0] = {16{32'hA5A5A5A5}}; valid_v = 2'b01;
    arb_cycle(2'b01);
    valid_v = 2'b00;
    #1; chk("haz0_full_row", RW'(rd_hazard_0), RW'(!BYP));
`ifdef REGBANK_WB_BYPASS_EN
    chk("byp_hit_0_full", RW'(byp_hit_0), RW'(1'b1));
    chk("byp_data_0", byp_data_0, {16{32'hA5A5A5A5}});
    chk("byp_hit_1_other", RW'(byp_hit_1), RW'(1'b0));
`endif
    arb_cycle(2'b00);
    src_addr[0] = 4'd2; src_mask[0] = 16'h00FF; valid_v = 2'b01;
    arb_cycle(2'b01);
    valid_v = 2'b00;
    #1; chk("haz0_partial", RW'(rd_hazard_0), RW'(1'b1));
`ifdef REGBANK_WB_BYPASS_EN
    chk("byp_hit_0_partial", RW'(byp_hit_0), RW'(1'b0));
`endif
    arb_cycle(2'b00);

    // async reset while the stage holds a write to reg 3
    src_addr[0] = 4'd3; src_mask[0] = 16'hFFFF; valid_v = 2'b01;
    arb_cycle(2'b01);
    valid_v = 2'b10;
    #2; rst_n = 1'b0;
    #1;
    chk("midrst_write_en", RW'(write_en), RW'(16'h0000));
    chk("midrst_waddr", RW'(waddr), RW'(4'h0));
    chk("midrst_wdata", wdata, {RW{1'b0}});
    chk("midrst_ready", RW'(req_ready), RW'(2'b00));
    @(posedge clk); #1;
    rst_n = 1'b1; valid_v = 2'b11;
    arb_cycle(2'b01);
    valid_v = 2'b10;
    arb_cycle(2'b10);
    valid_v = 2'b00;
    arb_cycle(2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
